spi_xfer_sched: RTL and testbench

Round-robin transfer scheduler that shares the single SPI master among `NREQ` byte-level requesters. It sits between requester logic and the SPI wrapper's SFR port. It grants one requester at a time and programs SPICR1, SPICR2, SPIBR and SPIDR1 over the SFR write bus. It drives the master slave-select vector, polls SPISR for completion, reads SPIDR2 back, and returns the received byte with an ack or timeout error.

---
 rtl/spi_pkg.sv | 38 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/spi_xfer_sched.sv | 199 +++++++++++++++++++
 tb/tb_spi_xfer_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI transfer scheduler: SFR map, SPISR bits, FSM states.
package spi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned SS_W   = 8;

  localparam logic [ADDR_W-1:0] ADDR_CR1 = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CR2 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_BR  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_DR1 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SR  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DR2 = 3'd5;

  localparam int unsigned SR_SPIF_BIT = 0;

  localparam logic [DATA_W-1:0] CR1_FORCE = 8'h10;
  localparam logic [DATA_W-1:0] CR2_VALUE = 8'h01;
  localparam logic [DATA_W-1:0] TMO_RDATA = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_CR1    = 4'd1,
    ST_WR_CR2    = 4'd2,
    ST_WR_BR     = 4'd3,
    ST_WR_DR     = 4'd4,
    ST_WAIT_CLR  = 4'd5,
    ST_WAIT_DONE = 4'd6,
    ST_RD        = 4'd7,
    ST_ACK       = 4'd8
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sfr_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [N-1:0]  gnt_oh_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    gnt_idx_o = '0;
    gnt_oh_o  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!found && req_i[IW'(idx)]) begin
        found                = 1'b1;
        gnt_idx_o            = IW'(idx);
        gnt_oh_o[IW'(idx)]   = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one SPI master among NREQ byte requesters via the SFR port.
module spi_xfer_sched
  import spi_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned TMO  = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_cr1,
  input  logic [8*NREQ-1:0]    req_br,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [DATA_W-1:0]    rdata,
  output logic                 busy,
  output logic                 sfrwe,
  output logic [ADDR_W-1:0]    sfraddr_w,
  output logic [ADDR_W-1:0]    sfraddr_r,
  output logic [DATA_W-1:0]    spidata_o,
  input  logic [DATA_W-1:0]    sfrdata_i,
  output logic [SS_W-1:0]      spssn_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d, ptr_q, ptr_d, arb_idx;
  logic [NREQ-1:0]      gnt_oh_q, gnt_oh_d, arb_oh;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 arb_any, tmo_hit;

  logic [NREQ-1:0]      ack_q, ack_d;
  logic                 err_q, err_d, busy_q, busy_d, sfrwe_q, sfrwe_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic [SS_W-1:0]      spssn_q, spssn_d;
  sfr_wr_t              wr_q, wr_d;

  logic [DATA_W-1:0]    cr1_a   [NREQ];
  logic [DATA_W-1:0]    br_a    [NREQ];
  logic [DATA_W-1:0]    wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign cr1_a[i]   = req_cr1[8*i +: 8];
    assign br_a[i]    = req_br[8*i +: 8];
    assign wdata_a[i] = req_wdata[8*i +: 8];
  end

  rr_arbiter #(.N(NREQ), .IW(IDX_W)) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .any_o     (arb_any),
    .gnt_idx_o (arb_idx),
    .gnt_oh_o  (arb_oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state plus output next-values; outputs are registered from the next state.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tmo_hit  = (cnt_q == CNT_W'(TMO - 1));

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d  = ST_WR_CR1;
          gnt_d    = arb_idx;
          gnt_oh_d = arb_oh;
        end
      end
      ST_WR_CR1: state_d = ST_WR_CR2;
      ST_WR_CR2: state_d = ST_WR_BR;
      ST_WR_BR:  state_d = ST_WR_DR;
      ST_WR_DR: begin
        state_d = ST_WAIT_CLR;
        cnt_d   = '0;
      end
      // Waiting for SPIF low first rejects a finish flag left over from the previous byte.
      ST_WAIT_CLR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit)                           state_d = ST_ACK;
        else if (!sfrdata_i[SR_SPIF_BIT])      state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit)                           state_d = ST_ACK;
        else if (sfrdata_i[SR_SPIF_BIT])       state_d = ST_RD;
      end
      ST_RD: state_d = ST_ACK;
      ST_ACK: begin
        state_d = ST_IDLE;
        ptr_d   = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : IDX_W'(gnt_q + 1'b1);
      end
      default: state_d = ST_IDLE;
    endcase

    sfrwe_d = 1'b0;
    wr_d    = wr_q;
    raddr_d = ADDR_SR;
    spssn_d = '1;
    busy_d  = (state_d != ST_IDLE);
    ack_d   = '0;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_d)
      ST_WR_CR1: begin
        sfrwe_d     = 1'b1;
        wr_d.addr   = ADDR_CR1;
        wr_d.data   = cr1_a[gnt_d] | CR1_FORCE;
      end
      ST_WR_CR2: begin
        sfrwe_d     = 1'b1;
        wr_d.addr   = ADDR_CR2;
        wr_d.data   = CR2_VALUE;
      end
      ST_WR_BR: begin
        sfrwe_d     = 1'b1;
        wr_d.addr   = ADDR_BR;
        wr_d.data   = br_a[gnt_d];
      end
      ST_WR_DR: begin
        sfrwe_d     = 1'b1;
        wr_d.addr   = ADDR_DR1;
        wr_d.data   = wdata_a[gnt_d];
      end
      ST_RD:   raddr_d = ADDR_DR2;
      ST_ACK:  ack_d   = gnt_oh_d;
      default: ;
    endcase

    if (state_d inside {ST_WR_DR, ST_WAIT_CLR, ST_WAIT_DONE, ST_RD}) begin
      spssn_d[3'(gnt_d)] = 1'b0;
    end

    if (state_q == ST_RD) begin
      rdata_d = sfrdata_i;
      err_d   = 1'b0;
    end else if ((state_q == ST_WAIT_CLR || state_q == ST_WAIT_DONE) && state_d == ST_ACK) begin
      rdata_d = TMO_RDATA;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      sfrwe_q <= 1'b0;
      wr_q    <= '0;
      raddr_q <= ADDR_SR;
      spssn_q <= '1;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      sfrwe_q <= sfrwe_d;
      wr_q    <= wr_d;
      raddr_q <= raddr_d;
      spssn_q <= spssn_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign sfrwe     = sfrwe_q;
  assign sfraddr_w = wr_q.addr;
  assign spidata_o = wr_q.data;
  assign sfraddr_r = raddr_q;
  assign spssn_o   = spssn_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Bench for spi_xfer_sched: SPI slave/SFR model, transaction-level expectation model, directed tests.
module tb_spi_xfer_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_cr1   = {8'h81, 8'h42, 8'h05, 8'h20};
  logic [8*NREQ-1:0] req_br    = {8'h07, 8'h01, 8'h03, 8'h00};
  logic [8*NREQ-1:0] req_wdata = {8'hC3, 8'h96, 8'hA5, 8'h11};
  logic [NREQ-1:0]   ack;
  logic              err, busy, sfrwe;
  logic [7:0]        rdata, spidata_o, sfrdata_i, spssn_o;
  logic [2:0]        sfraddr_w, sfraddr_r;

  always #5 clk = ~clk;

  spi_xfer_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cr1(req_cr1), .req_br(req_br),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .sfraddr_r(sfraddr_r),
    .spidata_o(spidata_o), .sfrdata_i(sfrdata_i), .spssn_o(spssn_o)
  );

  // SPI slave: SPIF stays set (stale) for clr_lat cycles after a DR write, then sets at done_lat.
  int         cyc_n = 0;
  int         dr_cyc = 0;
  bit         armed = 1'b0;
  int         clr_lat = 0;
  int         done_lat = 1;
  logic [7:0] slv_rdata = 8'h00;
  logic       spif;
  int         rel;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (!rst && sfrwe && sfraddr_w == 3'd3) begin
      armed  <= 1'b1;
      dr_cyc <= cyc_n;
    end
  end

  always_comb begin
    rel  = cyc_n - dr_cyc - 1;
    spif = 1'b0;
    if (armed) begin
      if (rel < clr_lat)                       spif = 1'b1;
      else if (done_lat >= 0 && rel >= done_lat) spif = 1'b1;
    end
  end

  assign sfrdata_i = (sfraddr_r == 3'd5) ? slv_rdata :
                     (sfraddr_r == 3'd3) ? {7'd0, spif} : 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
  endtask

  // Expectation model: walks one transfer at a time as a timeline of cycles.
  int         ptr_m;
  logic [2:0] e_waddr;
  logic [7:0] e_wdata, e_rdata;
  logic       e_err;
  bit         m_abort;

  task automatic cycle_chk(input logic e_we, input logic [2:0] e_ar, input logic [7:0] e_ss,
                           input logic e_busy, input logic [3:0] e_ack);
    @(negedge clk);
    if (rst) begin
      m_abort = 1'b1;
      return;
    end
    chk("sfrwe",     32'(sfrwe),     32'(e_we));
    chk("sfraddr_w", 32'(sfraddr_w), 32'(e_waddr));
    chk("spidata_o", 32'(spidata_o), 32'(e_wdata));
    chk("sfraddr_r", 32'(sfraddr_r), 32'(e_ar));
    chk("spssn_o",   32'(spssn_o),   32'(e_ss));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("ack",       32'(ack),       32'(e_ack));
    chk("rdata",     32'(rdata),     32'(e_rdata));
    if (e_ack != 4'd0) chk("err", 32'(err), 32'(e_err));
  endtask

  task automatic model_run();
    int         g;
    int         n;
    bit         clr_seen, tmo;
    logic [7:0] ss;
    m_abort = 1'b0;
    ptr_m   = 0;
    e_waddr = 3'd0;
    e_wdata = 8'h00;
    e_rdata = 8'h00;
    e_err   = 1'b0;
    forever begin
      cycle_chk(1'b0, 3'd3, 8'hFF, 1'b0, 4'd0);
      if (m_abort) return;
      if (req == '0) continue;
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && ((req >> ((ptr_m + i) % NREQ)) & 4'd1) != 4'd0) g = (ptr_m + i) % NREQ;
      end
      ss = 8'hFF & ~(8'd1 << g);
      for (int w = 0; w < 4; w++) begin
        e_waddr = 3'(w);
        case (w)
          0:       e_wdata = 8'(req_cr1 >> (8 * g)) | 8'h10;
          1:       e_wdata = 8'h01;
          2:       e_wdata = 8'(req_br >> (8 * g));
          default: e_wdata = 8'(req_wdata >> (8 * g));
        endcase
        cycle_chk(1'b1, 3'd3, (w == 3) ? ss : 8'hFF, 1'b1, 4'd0);
        if (m_abort) return;
      end
      n = 0;
      clr_seen = 1'b0;
      tmo = 1'b0;
      while (1) begin
        cycle_chk(1'b0, 3'd3, ss, 1'b1, 4'd0);
        if (m_abort) return;
        if (n == TMO - 1) begin
          tmo = 1'b1;
          break;
        end
        if (!clr_seen) begin
          if (!spif) clr_seen = 1'b1;
        end else if (spif) break;
        n++;
      end
      if (tmo) begin
        e_rdata = 8'hFF;
        e_err   = 1'b1;
      end else begin
        cycle_chk(1'b0, 3'd5, ss, 1'b1, 4'd0);
        if (m_abort) return;
        e_rdata = slv_rdata;
        e_err   = 1'b0;
      end
      cycle_chk(1'b0, 3'd3, 8'hFF, 1'b1, 4'(1 << g));
      if (m_abort) return;
      ptr_m = (g + 1) % NREQ;
    end
  endtask

  initial begin
    forever begin
      wait (rst == 1'b0);
      model_run();
      wait (rst == 1'b1);
    end
  end

  // Event log for the hand-computed expectations below.
  int          ack_cyc[$];
  int          ack_idx[$];
  logic [3:0]  ack_raw[$];
  logic [7:0]  ack_rd[$];
  logic [7:0]  ack_ssn[$];
  logic        ack_err[$];
  logic [10:0] wr_log[$];
  int          rd_cyc = 0;
  logic [7:0]  rd_ssn = 8'h00;

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = 99;
    for (int i = 0; i < NREQ; i++) if (v == 4'(1 << i)) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (sfrwe) wr_log.push_back({sfraddr_w, spidata_o});
      if (sfraddr_r == 3'd5) begin
        rd_cyc <= cyc_n;
        rd_ssn <= spssn_o;
      end
      if (ack != '0) begin
        ack_cyc.push_back(cyc_n);
        ack_idx.push_back(idx_of(ack));
        ack_raw.push_back(ack);
        ack_rd.push_back(rdata);
        ack_ssn.push_back(spssn_o);
        ack_err.push_back(err);
      end
    end
  end

  task automatic clear_logs();
    ack_cyc.delete(); ack_idx.delete(); ack_raw.delete();
    ack_rd.delete();  ack_ssn.delete(); ack_err.delete();
    wr_log.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int b;
    b = 0;
    while (ack_cyc.size() < n && b < budget) begin
      @(posedge clk);
      b++;
    end
    chk(nm, 32'(ack_cyc.size() >= n), 32'd1);
  endtask

  task automatic start_req(input logic [3:0] r, output int c0);
    @(posedge clk);
    #1;
    req = r;
    c0  = cyc_n;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",       32'(ack),       32'h0);
    chk("rst_err",       32'(err),       32'h0);
    chk("rst_rdata",     32'(rdata),     32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_sfrwe",     32'(sfrwe),     32'h0);
    chk("rst_sfraddr_w", 32'(sfraddr_w), 32'h0);
    chk("rst_sfraddr_r", 32'(sfraddr_r), 32'h3);
    chk("rst_spidata",   32'(spidata_o), 32'h0);
    chk("rst_spssn",     32'(spssn_o),   32'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester 1, minimum latency.
    clear_logs();
    clr_lat = 0; done_lat = 1; slv_rdata = 8'h3C;
    start_req(4'b0010, c0);
    wait_acks(1, 40, "t1_ack_arrives");
    #1 req = '0;
    chk("t1_nwr",    32'(wr_log.size()), 32'd4);
    chk("t1_wr_cr1", 32'(wr_log[0]), 32'({3'd0, 8'h15}));
    chk("t1_wr_cr2", 32'(wr_log[1]), 32'({3'd1, 8'h01}));
    chk("t1_wr_br",  32'(wr_log[2]), 32'({3'd2, 8'h03}));
    chk("t1_wr_dr",  32'(wr_log[3]), 32'({3'd3, 8'hA5}));
    chk("t1_ack",    32'(ack_raw[0]), 32'h2);
    chk("t1_rdata",  32'(ack_rd[0]),  32'h3C);
    chk("t1_err",    32'(ack_err[0]), 32'h0);
    chk("t1_ssn_rd", 32'(rd_ssn),     32'hFD);
    chk("t1_lat",    32'(ack_cyc[0] - c0), 32'd8);

    // All requesters held: strict rotation from ptr 0, back-to-back gap 9.
    do_reset();
    clear_logs();
    slv_rdata = 8'h5A;
    start_req(4'b1111, c0);
    wait_acks(5, 120, "t2_acks_arrive");
    #1 req = '0;
    chk("t2_lat", 32'(ack_cyc[0] - c0), 32'd8);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), 32'(ack_idx[i]), 32'(i % 4));
    for (int i = 1; i < 5; i++) chk($sformatf("t2_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd9);

    // Stale SPIF: three extra WAIT_CLR cycles, then SPIF sets two cycles into WAIT_DONE.
    clear_logs();
    clr_lat = 3; done_lat = 5; slv_rdata = 8'hC6;
    start_req(4'b0100, c0);
    wait_acks(1, 60, "t3_ack_arrives");
    #1 req = '0;
    chk("t3_idx",   32'(ack_idx[0]), 32'd2);
    chk("t3_rd",    32'(rd_cyc - c0), 32'd11);
    chk("t3_lat",   32'(ack_cyc[0] - c0), 32'd12);
    chk("t3_rdata", 32'(ack_rd[0]), 32'hC6);

    // Completion never arrives: timeout after TMO wait cycles.
    clear_logs();
    clr_lat = 0; done_lat = -1;
    start_req(4'b1000, c0);
    wait_acks(1, 80, "t4_ack_arrives");
    #1 req = '0;
    chk("t4_idx",   32'(ack_idx[0]), 32'd3);
    chk("t4_lat",   32'(ack_cyc[0] - c0), 32'd21);
    chk("t4_err",   32'(ack_err[0]), 32'h1);
    chk("t4_rdata", 32'(ack_rd[0]),  32'hFF);
    chk("t4_ssn",   32'(ack_ssn[0]), 32'hFF);

    // Reset during WAIT_DONE after moving ptr to 2; restart must grant from ptr 0.
    clear_logs();
    done_lat = 1; slv_rdata = 8'h77;
    start_req(4'b0010, c0);
    wait_acks(1, 40, "t5_pre_ack_arrives");
    #1 req = '0;
    done_lat = -1;
    start_req(4'b0100, c0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    #1;
    chk("t5_rst_ssn",   32'(spssn_o), 32'hFF);
    chk("t5_rst_busy",  32'(busy),    32'h0);
    chk("t5_rst_sfrwe", 32'(sfrwe),   32'h0);
    chk("t5_rst_ack",   32'(ack),     32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("t5_no_ack", 32'(ack_cyc.size()), 32'd1);
    clear_logs();
    done_lat = 1;
    start_req(4'b1001, c0);
    wait_acks(1, 40, "t5_ack_arrives");
    #1 req = '0;
    chk("t5_idx",     32'(ack_idx[0]), 32'd0);
    chk("t5_wr_cr1",  32'(wr_log[0]),  32'({3'd0, 8'h30}));
    chk("t5_rdata",   32'(ack_rd[0]),  32'h77);
    chk("t5_lat",     32'(ack_cyc[0] - c0), 32'd8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
